// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and types for the instruction-fetch stage.
//                FETCH_ADDR_W : PC / instruction-memory byte address width
//                INSTR_W      : instruction word width
//                NOP_INSTR    : word presented to decode when nothing is valid
//                fetch_entry_t: one {pc, instr} queue entry
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int FETCH_ADDR_W = 14;
  localparam int INSTR_W      = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Small synchronous FIFO of fetch_entry_t with flush.
//                Flush has priority over push and pop.
//  Ports       : i_clk, i_rst_n (async active-low)
//                i_push / i_data  : write entry at tail
//                i_pop            : retire head entry
//                i_flush          : empty the queue, reset pointers
//                o_full, o_empty, o_count, o_head (combinational head entry)
//  Parameters  : DEPTH (power of 2, >= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output fetch_entry_t           o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues the byte address
//                to instruction memory, captures the combinational read data
//                into a small queue and hands {pc, instr} to decode with a
//                valid/ready handshake. Redirects flush the queue.
//  Ports       : i_clk, i_rst_n (async active-low)
//                o_imem_addr / i_imem_rdata : instruction memory interface
//                i_stall                    : freeze fetch (drain continues)
//                i_redirect, i_redirect_pc  : redirect from execute
//                o_valid, i_ready, o_instr, o_pc : decode handshake
//                o_misalign                 : misaligned redirect target pulse
//                o_fetch_cnt, o_bubble_cnt  : only with FETCH_PERF_EN
//  Parameters  : ADDR_W (must match FETCH_ADDR_W), RESET_PC, DEPTH
//  Macros      : FETCH_PERF_EN - adds saturating pop / bubble counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_bubble_cnt
`endif
);

  logic [ADDR_W-1:0]      r_pc;
  logic                   r_misalign;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_valid;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  fetch_entry_t           w_wr_entry;
  fetch_entry_t           w_head;

  // Queued entries are younger than a redirecting instruction, so they are
  // hidden from decode in the same cycle the redirect is raised.
  assign w_valid = (w_count != '0) && !i_redirect;
  assign w_pop   = w_valid && i_ready;
  // When full, a push may still go ahead because the popped slot frees up.
  assign w_push  = !i_redirect && !i_stall && (!w_full || w_pop);

  assign w_wr_entry.pc    = r_pc;
  assign w_wr_entry.instr = i_imem_rdata;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  (w_wr_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Redirect outranks push; the target is word-aligned by dropping bits [1:0].
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= i_redirect && (|i_redirect_pc[1:0]);
      if (i_redirect)  r_pc <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
      else if (w_push) r_pc <= r_pc + ADDR_W'(4);
    end
  end

  assign o_imem_addr = r_pc;
  assign o_valid     = w_valid;
  assign o_misalign  = r_misalign;
  assign o_instr     = (w_empty || i_redirect) ? NOP_INSTR : w_head.instr;
  assign o_pc        = w_valid ? w_head.pc : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_pop && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_ready && !w_valid && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Instruction
//                memory word at byte address a holds 32'h1000_0000 | a[13:2].
//                Define FETCH_PERF_EN to also exercise the perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [13:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [13:0] pc;
  logic        misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  logic [31:0] mem [4096];

  int n_checks;
  int n_errors;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  fetch_unit #(
    .ADDR_W   (14),
    .RESET_PC (14'h0000),
    .DEPTH    (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_misalign    (misalign)
`ifdef FETCH_PERF_EN
    ,
    .o_fetch_cnt   (fetch_cnt),
    .o_bubble_cnt  (bubble_cnt)
`endif
  );

  assign imem_rdata = mem[imem_addr[13:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_instr(input logic [13:0] a);
    return 32'h1000_0000 | 32'(a[13:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 | i;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 14'h0;
    ready       = 1'b1;

    // Reset state
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instr, c_nop);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);

    // Streaming fetch after reset release
    step();
    rst_n = 1'b1;
    #1;
    check("pre_valid", 32'(valid), 32'd0);
    check("pre_addr", 32'(imem_addr), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("str_addr", 32'(imem_addr), 32'(4 * k));
      check("str_valid", 32'(valid), 32'd1);
      check("str_pc", 32'(pc), 32'(4 * (k - 1)));
      check("str_instr", instr, exp_instr(14'(4 * (k - 1))));
    end

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_addr", 32'(imem_addr), 32'd0);
    check("arst_instr", instr, c_nop);

    // Back-pressure fills the two-entry queue, then drains in order
    ready = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_pc", 32'(pc), 32'd0);
      check("bp_addr", 32'(imem_addr), (k == 1) ? 32'd4 : 32'd8);
    end
    ready = 1'b1;
    #1;
    check("drain0_pc", 32'(pc), 32'd0);
    check("drain0_instr", instr, exp_instr(14'h0));
    step();
    check("drain1_pc", 32'(pc), 32'h4);
    check("drain1_addr", 32'(imem_addr), 32'hC);
    step();
    check("drain2_pc", 32'(pc), 32'h8);
    check("drain2_addr", 32'(imem_addr), 32'h10);

    // Aligned redirect with two entries queued
    ready       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 14'h100;
    #1;
    check("rd_mask_valid", 32'(valid), 32'd0);
    check("rd_mask_instr", instr, c_nop);
    check("rd_mask_pc", 32'(pc), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("rd_addr", 32'(imem_addr), 32'h100);
    check("rd_empty", 32'(valid), 32'd0);
    check("rd_misalign", 32'(misalign), 32'd0);
    step();
    check("rd_valid", 32'(valid), 32'd1);
    check("rd_pc", 32'(pc), 32'h100);
    check("rd_addr2", 32'(imem_addr), 32'h104);
    check("rd_misalign2", 32'(misalign), 32'd0);

    // Misaligned redirect
    ready       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 14'h102;
    step();
    redirect = 1'b0;
    #1;
    check("mis_addr", 32'(imem_addr), 32'h100);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_valid", 32'(valid), 32'd0);
    step();
    check("mis_pulse_end", 32'(misalign), 32'd0);
    check("mis_pc", 32'(pc), 32'h100);
    check("mis_instr", instr, exp_instr(14'h100));

    // Back-to-back redirects: last wins
    redirect    = 1'b1;
    redirect_pc = 14'h203;
    step();
    check("b2b_addr1", 32'(imem_addr), 32'h200);
    check("b2b_mis1", 32'(misalign), 32'd1);
    redirect_pc = 14'h300;
    step();
    redirect = 1'b0;
    #1;
    check("b2b_addr2", 32'(imem_addr), 32'h300);
    check("b2b_mis2", 32'(misalign), 32'd0);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 14'h3FF8;
    step();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", 32'(imem_addr), 32'h3FF8);
    step();
    check("wrap_addr1", 32'(imem_addr), 32'h3FFC);
    check("wrap_pc1", 32'(pc), 32'h3FF8);
    step();
    check("wrap_addr2", 32'(imem_addr), 32'h0000);
    check("wrap_pc2", 32'(pc), 32'h3FFC);
    check("wrap_instr2", instr, exp_instr(14'h3FFC));

    // Stall: drain continues, PC holds
    stall = 1'b1;
    step();
    check("stall_valid", 32'(valid), 32'd0);
    check("stall_addr", 32'(imem_addr), 32'h0);
    step();
    check("stall_addr2", 32'(imem_addr), 32'h0);
    stall = 1'b0;
    step();
    check("unstall_valid", 32'(valid), 32'd1);
    check("unstall_pc", 32'(pc), 32'h0);
    check("unstall_addr", 32'(imem_addr), 32'h4);

`ifdef FETCH_PERF_EN
    // Performance counters: 2 bubbles then 3 pops
    rst_n = 1'b0;
    ready = 1'b1;
    #1;
    check("perf_rst_fetch", fetch_cnt, 32'd0);
    check("perf_rst_bubble", bubble_cnt, 32'd0);
    step();
    rst_n = 1'b1;
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    step();
    step();
    step();
    ready = 1'b0;
    #1;
    check("perf_fetch", fetch_cnt, 32'd3);
    check("perf_bubble", bubble_cnt, 32'd2);
    step();
    check("perf_fetch_hold", fetch_cnt, 32'd3);
    check("perf_bubble_hold", bubble_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into the instruction memory. It receives the combinational read data back in the same cycle.
- Buffers {pc, instr} pairs in a small queue and presents them to decode with a valid/ready handshake.
- Handles stalls, and handles branch/jump redirects from execute, which flush the queue.

Parameters:
- ADDR_W, 14, width of PC and instruction-memory byte address.
- RESET_PC, 14'h0000, PC value after reset.
- DEPTH, 2, queue entries; power of 2, minimum 2.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- o_imem_addr  output  ADDR_W  byte address to instruction memory; equals the PC register.
- i_imem_rdata  input  32  instruction word returned combinationally for o_imem_addr.
- i_stall  input  1  freezes fetch (no push, PC holds); draining to decode continues.
- i_redirect  input  1  redirect request from execute.
- i_redirect_pc  input  ADDR_W  redirect target.
- o_valid  output  1  head entry valid toward decode.
- i_ready  input  1  decode accepts head entry.
- o_instr  output  32  head instruction; NOP 32'h0000_0013 when o_valid=0.
- o_pc  output  ADDR_W  head PC; 0 when o_valid=0.
- o_misalign  output  1  one-cycle pulse: redirect target had non-zero bits [1:0].

Behaviour:
- Reset (async, i_rst_n=0):
  - PC=RESET_PC; queue empty, pointers and count 0; o_misalign=0.
  - Outputs during reset: o_valid=0, o_instr=NOP, o_pc=0, o_imem_addr=RESET_PC.
- Reset mid-operation: all state is cleared immediately, without waiting for a clock edge. The first fetch is at RESET_PC on the first edge after release.
- pop = o_valid & i_ready.
- o_valid = (count!=0) & ~i_redirect. Queue contents are younger than the redirecting instruction, so they are masked in the same cycle.
- push = ~i_redirect & ~i_stall & (count<DEPTH | pop). A push stores {PC, i_imem_rdata} at the tail and sets PC<=PC+4.
- Latency: a word fetched at edge N is visible on o_valid/o_instr in the cycle after edge N, i.e. one cycle after address issue. The queue is not bypassed.
- Full: push proceeds only if pop occurs in the same cycle. Otherwise the PC holds and o_imem_addr is stable.
- Empty: o_valid=0, o_instr=NOP, o_pc=0. Simultaneous push and pop on an empty queue is impossible, because o_valid=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (i_redirect=1 at an edge) takes priority over stall, push and pop:
  - Queue flushed (count=0, pointers reset).
  - PC<=i_redirect_pc with bits [1:0] forced to 0.
  - o_misalign<=|i_redirect_pc[1:0] for exactly that next cycle.
- Back-to-back redirects: the last one wins; each misaligned one pulses o_misalign.
- Arithmetic: PC+4 is modulo 2^ADDR_W, so 14'h3FFC wraps to 14'h0000. Queue pointers are log2(DEPTH) bits and wrap naturally.
- State summary: RUN (push allowed), STALLED (i_stall), FULL (count==DEPTH, no pop). These states are derived from inputs and count; no separate FSM register is needed.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs o_fetch_cnt[31:0] and o_bubble_cnt[31:0], both reset to 0.
  - o_fetch_cnt increments on every pop.
  - o_bubble_cnt increments on each cycle with i_ready=1 and o_valid=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist, and there is no other behavioural change.

Decomposition:
- Package fetch_pkg contains:
  - INSTR_W=32 and NOP_INSTR=32'h0000_0013.
  - typedef fetch_entry_t: packed struct {logic [ADDR_W-1:0] pc; logic [31:0] instr}, with ADDR_W taken from a package constant FETCH_ADDR_W=14.
- Sub-module fetch_queue:
  - Parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count, head.
- fetch_unit keeps the PC, push/pop/redirect logic and the optional counters.

Test Plan:
- Reset release, i_ready=1, memory preloaded 0x00..0x0C = A,B,C,D: o_imem_addr steps 0,4,8,C. o_valid rises the cycle after the first edge; o_instr/o_pc stream A/0, B/4, C/8, D/C, one per cycle.
- i_ready=0 for 5 cycles with DEPTH=2: queue fills with pc 0 and 4, o_imem_addr holds 8, o_valid=1 with o_pc=0 throughout. Raising i_ready delivers 0, 4, 8 in order with no duplicate or loss.
- Redirect to 0x100 while the queue holds 2 entries: o_valid=0 in the redirect cycle. The next edge has o_imem_addr=0x100 and empty queue, then o_pc=0x100 one cycle later; o_misalign stays 0.
- Redirect to 0x102: o_imem_addr=0x100 and o_misalign=1 for exactly one cycle.
- PC at 14'h3FFC with no stall: next fetch address is 14'h0000. Assert i_rst_n=0 mid-stream: o_valid drops immediately (asynchronous) and o_imem_addr=RESET_PC.
- With FETCH_PERF_EN defined: 3 pops and 2 cycles of (i_ready=1, o_valid=0) give o_fetch_cnt=3 and o_bubble_cnt=2.
